// File: rtl/q_sys_onchip_ram_pipe.sv
// Single-port on-chip RAM with an Avalon-MM pipelined slave port: byte-lane writes,
// 1- or 2-cycle read latency with readdatavalid, and an optional zero-fill after reset.
module q_sys_onchip_ram_pipe #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 9,
    parameter int    DEPTH          = 512,
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = "q_sys_onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    clear_busy
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("q_sys_onchip_ram_pipe: READ_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
            $error("q_sys_onchip_ram_pipe: DATA_WIDTH must be a multiple of 8 in 8..128");
        end
        if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
            $error("q_sys_onchip_ram_pipe: DEPTH must be in 1..2**ADDR_WIDTH");
        end
        // Without the zero-fill the power-up contents come from the configuration image.
        if (CLEAR_ON_RESET == 0 && INIT_FILE == "") begin : g_no_init
            $error("q_sys_onchip_ram_pipe: INIT_FILE must name the initial contents");
        end
    endgenerate

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_addr_q, clr_addr_d;

    logic             ce;
    logic             in_range;
    logic             cmd_acc, rd_acc, wr_acc;
    logic [IDX_W-1:0] rd_idx;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [NB-1:0]    mem_be;
    logic [NB-1:0]    lane_we;
    logic [DATA_WIDTH-1:0] mem_wd;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  vld1_q, rng1_q;
    logic [DATA_WIDTH-1:0] stage1_data;
    logic                  last_vld;
    logic [DATA_WIDTH-1:0] last_data;

    assign ce          = clken & ~reset_req;
    assign waitrequest = (state_q != ST_READY) | ~ce;
    assign clear_busy  = (state_q == ST_CLEAR);
    assign in_range    = {1'b0, address} < DEPTH_L;
    assign rd_idx      = address[IDX_W-1:0];
    assign cmd_acc     = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = cmd_acc & write;
    assign rd_acc      = cmd_acc & read & ~write;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_RESET: begin
                clr_addr_d = '0;
                state_d    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                if (ce) begin
                    if (clr_addr_q == LAST_IDX) begin
                        state_d = ST_READY;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // The zero-fill borrows the single write port; commands are held off meanwhile.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = rd_idx;
        mem_be  = byteenable;
        mem_wd  = writedata;
        if (state_q == ST_CLEAR) begin
            mem_we  = ce & ~reset;
            mem_idx = clr_addr_q;
            mem_be  = '1;
            mem_wd  = '0;
        end else begin
            mem_we = wr_acc & in_range & ~reset;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_we[gi] = mem_we & mem_be[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
        if (ce) begin
            ram_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld1_q <= 1'b0;
            rng1_q <= 1'b0;
        end else if (ce) begin
            vld1_q <= rd_acc;
            rng1_q <= rd_acc & in_range;
        end
    end

    // Out-of-range reads (and idle slots) present zero instead of the RAM output.
    assign stage1_data = rng1_q ? ram_q : '0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld2_q;
            logic [DATA_WIDTH-1:0] dat2_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld2_q <= 1'b0;
                    dat2_q <= '0;
                end else if (ce) begin
                    vld2_q <= vld1_q;
                    dat2_q <= stage1_data;
                end
            end
            assign last_vld  = vld2_q;
            assign last_data = dat2_q;
        end else begin : g_lat1
            assign last_vld  = vld1_q;
            assign last_data = stage1_data;
        end
    endgenerate

    assign readdata      = last_data;
    assign readdatavalid = last_vld & ce;

endmodule

// File: tb/tb_q_sys_onchip_ram_pipe.sv
// Bench for q_sys_onchip_ram_pipe: two configurations driven in lock-step and checked
// every cycle against a behavioural memory/response-queue model, plus literal checks.
module tb_q_sys_onchip_ram_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, reset_req, clken, chipselect, read, write;
    logic [AW-1:0] address;
    logic [NB-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] rdata [2];
    logic          rvalid [2];
    logic          wreq [2];
    logic          cbusy [2];

    // a: LAT=1, no zero-fill, DEPTH=20.  b: LAT=2, zero-fill, DEPTH=24.
    q_sys_onchip_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(20),
                            .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_a (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .chipselect(chipselect), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(rdata[0]),
        .readdatavalid(rvalid[0]), .waitrequest(wreq[0]), .clear_busy(cbusy[0]));

    q_sys_onchip_ram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(24),
                            .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .chipselect(chipselect), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(rdata[1]),
        .readdatavalid(rvalid[1]), .waitrequest(wreq[1]), .clear_busy(cbusy[1]));

    function automatic int depth_of(input int i); return (i == 0) ? 20 : 24; endfunction
    function automatic int lat_of(input int i);   return (i == 0) ? 1 : 2;   endfunction
    function automatic bit clr_of(input int i);   return (i == 1);           endfunction

    // Model state: memory with per-byte "known" flags and outstanding read responses.
    bit          in_rst [2] = '{1'b1, 1'b1};
    int          clr_left [2] = '{0, 0};
    logic [31:0] mmem [2][32];
    logic [3:0]  mknown [2][32] = '{default: '0};
    int          pend_n [2] = '{0, 0};
    int          pend_cnt [2][4];
    logic [31:0] pend_dat [2][4];
    logic [3:0]  pend_kn [2][4];

    bit          check_en = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    bit          snap_v [2];
    bit          snap_cb [2];
    bit          snap_wr [2];
    logic [31:0] snap_d [2];
    logic [31:0] got_d [2][16];
    int          got_n [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic model_edge(input int i);
        bit ce;
        int a;
        int idx;
        ce = clken && !reset_req;
        a  = int'(address);
        if (reset) begin
            in_rst[i] = 1'b1; clr_left[i] = 0; pend_n[i] = 0;
            return;
        end
        if (in_rst[i]) begin
            in_rst[i]   = 1'b0;
            clr_left[i] = clr_of(i) ? depth_of(i) : 0;
            return;
        end
        if (clr_left[i] > 0) begin
            if (ce) begin
                idx = depth_of(i) - clr_left[i];
                mmem[i][idx] = '0; mknown[i][idx] = 4'hF;
                clr_left[i]--;
            end
            return;
        end
        if (ce && chipselect && (read || write)) begin
            if (write) begin
                if (a < depth_of(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (byteenable[b]) begin
                            mmem[i][a][8*b +: 8] = writedata[8*b +: 8];
                            mknown[i][a][b] = 1'b1;
                        end
                    end
                end
            end else begin
                pend_cnt[i][pend_n[i]] = lat_of(i);
                pend_dat[i][pend_n[i]] = (a < depth_of(i)) ? mmem[i][a] : 32'h0;
                pend_kn[i][pend_n[i]]  = (a < depth_of(i)) ? mknown[i][a] : 4'hF;
                pend_n[i]++;
            end
        end
    endtask

    task automatic compare_inst(input int i);
        bit          ce, exp_v, exp_wr, exp_cb;
        logic [31:0] ed, mask;
        logic [3:0]  ek;
        string       nm;
        nm = (i == 0) ? "a" : "b";
        ce = clken && !reset_req;
        snap_v[i] = rvalid[i]; snap_cb[i] = cbusy[i]; snap_wr[i] = wreq[i]; snap_d[i] = rdata[i];
        exp_wr = in_rst[i] || (clr_left[i] > 0) || !ce;
        exp_cb = !in_rst[i] && (clr_left[i] > 0);
        exp_v = 1'b0; ed = '0; ek = '0;
        // Each response needs LAT enabled cycles after acceptance to surface.
        if (ce && pend_n[i] > 0) begin
            for (int k = 0; k < pend_n[i]; k++) pend_cnt[i][k]--;
            if (pend_cnt[i][0] == 0) begin
                exp_v = 1'b1; ed = pend_dat[i][0]; ek = pend_kn[i][0];
                for (int k = 0; k < pend_n[i] - 1; k++) begin
                    pend_cnt[i][k] = pend_cnt[i][k+1];
                    pend_dat[i][k] = pend_dat[i][k+1];
                    pend_kn[i][k]  = pend_kn[i][k+1];
                end
                pend_n[i]--;
            end
        end
        if (!check_en) return;
        chk({nm, ".waitrequest"}, 32'(wreq[i]), 32'(exp_wr));
        chk({nm, ".clear_busy"}, 32'(cbusy[i]), 32'(exp_cb));
        chk({nm, ".readdatavalid"}, 32'(rvalid[i]), 32'(exp_v));
        if (exp_v && rvalid[i] === 1'b1) begin
            mask = '0;
            for (int b = 0; b < NB; b++) if (ek[b]) mask[8*b +: 8] = 8'hFF;
            if (mask != 0) chk({nm, ".readdata"}, rdata[i] & mask, ed & mask);
        end
        if (in_rst[i]) chk({nm, ".readdata_reset"}, rdata[i], 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare_inst(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic set_cmd(input bit rd, input bit wr, input int a, input logic [3:0] be,
                           input logic [31:0] d);
        chipselect = 1'b1; read = rd; write = wr;
        address = AW'(a); byteenable = be; writedata = d;
    endtask

    task automatic clear_got();
        for (int i = 0; i < 2; i++) begin
            got_n[i] = 0;
            for (int k = 0; k < 16; k++) got_d[i][k] = 'x;
        end
    endtask

    task automatic collect();
        for (int i = 0; i < 2; i++) begin
            if (snap_v[i] && got_n[i] < 16) begin
                got_d[i][got_n[i]] = snap_d[i];
                got_n[i]++;
            end
        end
    endtask

    task automatic do_write(input int a, input logic [3:0] be, input logic [31:0] d);
        set_cmd(1'b0, 1'b1, a, be, d); tick(); idle();
    endtask

    task automatic read_expect(input int a, input logic [31:0] exp_a, input logic [31:0] exp_b,
                               input string tag);
        set_cmd(1'b1, 1'b0, a, 4'hF, 32'h0); tick(); idle();
        clear_got();
        repeat (4) begin tick(); collect(); end
        chk({"a.", tag, ".count"}, 32'(got_n[0]), 32'd1);
        chk({"b.", tag, ".count"}, 32'(got_n[1]), 32'd1);
        chk({"a.", tag, ".data"}, got_d[0][0], exp_a);
        chk({"b.", tag, ".data"}, got_d[1][0], exp_b);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        tick();
        check_en = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Zero-fill of b lasts exactly DEPTH enabled cycles.
        cnt = 0;
        repeat (40) begin tick(); if (snap_cb[1]) cnt++; end
        chk("b.clear_busy_cycles", 32'(cnt), 32'd24);

        do_write(5, 4'hF, 32'hDEADBEEF);
        read_expect(5, 32'hDEADBEEF, 32'hDEADBEEF, "raw");

        do_write(7, 4'hF, 32'h11223344);
        do_write(7, 4'b0101, 32'hAABBCCDD);
        read_expect(7, 32'h11BB33DD, 32'h11BB33DD, "bytelanes");

        do_write(28, 4'hF, 32'h5);
        read_expect(28, 32'h0, 32'h0, "out_of_range");

        // read and write together: write lands, no response.
        set_cmd(1'b1, 1'b1, 3, 4'hF, 32'h0BADF00D); tick(); idle();
        clear_got();
        repeat (4) begin tick(); collect(); end
        chk("a.rw_both.count", 32'(got_n[0]), 32'd0);
        chk("b.rw_both.count", 32'(got_n[1]), 32'd0);
        read_expect(3, 32'h0BADF00D, 32'h0BADF00D, "rw_both_readback");

        // Back-to-back reads with clken dropped for two cycles mid-burst.
        for (int k = 0; k < 4; k++) do_write(k, 4'hF, 32'h100 + k);
        clear_got();
        set_cmd(1'b1, 1'b0, 0, 4'hF, 32'h0); tick(); collect();
        set_cmd(1'b1, 1'b0, 1, 4'hF, 32'h0); tick(); collect();
        clken = 1'b0;
        set_cmd(1'b1, 1'b0, 2, 4'hF, 32'h0);
        tick(); collect();
        chk("a.stall_waitrequest", 32'(snap_wr[0]), 32'd1);
        chk("b.stall_waitrequest", 32'(snap_wr[1]), 32'd1);
        tick(); collect();
        clken = 1'b1;
        tick(); collect();
        set_cmd(1'b1, 1'b0, 3, 4'hF, 32'h0); tick(); collect();
        idle();
        repeat (5) begin tick(); collect(); end
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "a.burst.count" : "b.burst.count", 32'(got_n[i]), 32'd4);
            for (int k = 0; k < 4; k++)
                chk(i == 0 ? "a.burst.data" : "b.burst.data", got_d[i][k], 32'h100 + k);
        end

        // Reset the cycle after a read is accepted: the LAT=2 read must vanish.
        set_cmd(1'b1, 1'b0, 1, 4'hF, 32'h0); tick(); idle();
        reset = 1'b1;
        clear_got();
        tick(); collect(); tick(); collect();
        reset = 1'b0;
        repeat (40) begin tick(); collect(); end
        chk("b.reset_mid_read.count", 32'(got_n[1]), 32'd0);
        // a keeps its contents across reset, b is zero-filled.
        read_expect(5, 32'hDEADBEEF, 32'h0, "after_reset");

        for (int n = 0; n < 2000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            reset_req  = ($urandom_range(0, 24) == 0);
            clken      = ($urandom_range(0, 9) != 0);
            chipselect = reset ? 1'b0 : ($urandom_range(0, 3) != 0);
            read       = $urandom_range(0, 1) == 1;
            write      = $urandom_range(0, 2) == 0;
            address    = AW'($urandom_range(0, 31));
            byteenable = NB'($urandom);
            writedata  = $urandom;
            tick();
        end
        reset = 1'b0; reset_req = 1'b0; clken = 1'b1; idle();
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
